// File: rtl/pp_reduce_seq.sv
// Serial Booth partial-product reducer: one 4-2 compressor is reused every beat,
// folding two partial products into a running carry-save accumulator.

module compressor4_2 #(
    parameter int W = 66
) (
    input  logic [W-1:0] i0,
    input  logic [W-1:0] i1,
    input  logic [W-1:0] i2,
    input  logic [W-1:0] i3,
    input  logic         ci,
    output logic [W-1:0] d,
    output logic [W-1:0] c,
    output logic         co
);
    logic [W-1:0] s1;
    logic [W-1:0] cout_v;
    logic [W-1:0] cin_v;

    // Two cascaded full-adder rows; the first row's carries ripple one bit sideways.
    always_comb begin
        s1     = i0 ^ i1 ^ i2;
        cout_v = (i0 & i1) | (i0 & i2) | (i1 & i2);
        cin_v  = {cout_v[W-2:0], ci};
        d      = s1 ^ i3 ^ cin_v;
        c      = (s1 & i3) | (s1 & cin_v) | (i3 & cin_v);
        co     = cout_v[W-1];
    end
endmodule

// state  | meaning
// IDLE   | waiting for start, results of the last operation held
// ACC    | accepting beats, two partial products per handshake
// DONE   | one-cycle result-valid pulse
module pp_reduce_seq #(
    parameter int LENGTH = 32,
    parameter int PP_NUM = 17
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  start,
    input  logic                  pp_valid,
    output logic                  pp_ready,
    input  logic [2*LENGTH+1:0]   pp0_data,
    input  logic [2*LENGTH+1:0]   pp1_data,
    output logic                  busy,
    output logic                  done,
    output logic [2*LENGTH+1:0]   sum_out,
    output logic [2*LENGTH+1:0]   carry_out
);
    localparam int W  = 2 * LENGTH + 2;
    localparam int B  = (PP_NUM + 1) / 2;
    localparam int CW = $clog2(B + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(B - 1);
    localparam bit ODD_PP = (PP_NUM % 2) == 1;

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  acc_s_q, acc_s_d;
    logic [W-1:0]  acc_c_q, acc_c_d;
    logic [CW-1:0] beat_cnt_q, beat_cnt_d;
    logic          pp_ready_q, pp_ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          hs;
    logic          last_beat;
    logic [W-1:0]  pp1_eff;
    logic [W-1:0]  comp_d;
    logic [W-1:0]  comp_c;
    logic          comp_co;
    logic          carry_unused;

    always_comb begin
        hs        = pp_valid & pp_ready_q;
        last_beat = beat_cnt_q == LAST_BEAT;
        // Odd count: the final beat carries only one real partial product.
        pp1_eff   = (ODD_PP && last_beat) ? '0 : pp1_data;
    end

    compressor4_2 #(.W(W)) u_comp (
        .i0 (acc_s_q),
        .i1 (acc_c_q),
        .i2 (pp0_data),
        .i3 (pp1_eff),
        .ci (1'b0),
        .d  (comp_d),
        .c  (comp_c),
        .co (comp_co)
    );

    // Bits shifted out beyond W are dropped, so the accumulator works mod 2^W.
    assign carry_unused = comp_co ^ comp_c[W-1];

    always_comb begin
        state_d    = state_q;
        acc_s_d    = acc_s_q;
        acc_c_d    = acc_c_q;
        beat_cnt_d = beat_cnt_q;
        pp_ready_d = pp_ready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_ACC;
                    acc_s_d    = '0;
                    acc_c_d    = '0;
                    beat_cnt_d = '0;
                    pp_ready_d = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            S_ACC: begin
                if (hs) begin
                    acc_s_d    = comp_d;
                    acc_c_d    = {comp_c[W-2:0], 1'b0};
                    beat_cnt_d = beat_cnt_q + CW'(1);
                    if (last_beat) begin
                        state_d    = S_DONE;
                        pp_ready_d = 1'b0;
                        done_d     = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d    = S_IDLE;
                pp_ready_d = 1'b0;
                busy_d     = 1'b0;
            end
            default: begin
                state_d    = S_IDLE;
                pp_ready_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= S_IDLE;
            acc_s_q    <= '0;
            acc_c_q    <= '0;
            beat_cnt_q <= '0;
            pp_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_s_q    <= acc_s_d;
            acc_c_q    <= acc_c_d;
            beat_cnt_q <= beat_cnt_d;
            pp_ready_q <= pp_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign pp_ready  = pp_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign sum_out   = acc_s_q;
    assign carry_out = acc_c_q;
endmodule

// File: tb/tb_pp_reduce_seq.sv
// Bench for pp_reduce_seq: four parameterisations driven from shared tasks,
// checked against a plain modular-sum reference.

module tb_pp_reduce_seq;
    logic        clk;
    logic        rst;
    logic        start    [4];
    logic        pp_valid [4];
    logic [65:0] pp0      [4];
    logic [65:0] pp1      [4];
    wire         ready_w  [4];
    wire         busy_w   [4];
    wire         done_w   [4];
    wire  [65:0] sum_w    [4];
    wire  [65:0] carry_w  [4];
    wire  [9:0]  sum0_w;
    wire  [9:0]  carry0_w;

    int n_checks = 0;
    int n_err    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign sum_w[0]   = {56'd0, sum0_w};
    assign carry_w[0] = {56'd0, carry0_w};

    pp_reduce_seq #(.LENGTH(4), .PP_NUM(3)) u_dut0 (
        .sys_clk(clk), .sys_rst(rst), .start(start[0]), .pp_valid(pp_valid[0]),
        .pp_ready(ready_w[0]), .pp0_data(pp0[0][9:0]), .pp1_data(pp1[0][9:0]),
        .busy(busy_w[0]), .done(done_w[0]), .sum_out(sum0_w), .carry_out(carry0_w));
    pp_reduce_seq #(.LENGTH(32), .PP_NUM(17)) u_dut1 (
        .sys_clk(clk), .sys_rst(rst), .start(start[1]), .pp_valid(pp_valid[1]),
        .pp_ready(ready_w[1]), .pp0_data(pp0[1]), .pp1_data(pp1[1]),
        .busy(busy_w[1]), .done(done_w[1]), .sum_out(sum_w[1]), .carry_out(carry_w[1]));
    pp_reduce_seq #(.LENGTH(32), .PP_NUM(1)) u_dut2 (
        .sys_clk(clk), .sys_rst(rst), .start(start[2]), .pp_valid(pp_valid[2]),
        .pp_ready(ready_w[2]), .pp0_data(pp0[2]), .pp1_data(pp1[2]),
        .busy(busy_w[2]), .done(done_w[2]), .sum_out(sum_w[2]), .carry_out(carry_w[2]));
    pp_reduce_seq #(.LENGTH(32), .PP_NUM(2)) u_dut3 (
        .sys_clk(clk), .sys_rst(rst), .start(start[3]), .pp_valid(pp_valid[3]),
        .pp_ready(ready_w[3]), .pp0_data(pp0[3]), .pp1_data(pp1[3]),
        .busy(busy_w[3]), .done(done_w[3]), .sum_out(sum_w[3]), .carry_out(carry_w[3]));

    typedef struct {
        int                 n;
        logic [16:0][65:0]  pp;
        logic [8:0][3:0]    gaps;
        logic [65:0]        exp_sum;
        int                 exp_lat;
    } vec_t;

    vec_t tbl [3];

    function automatic int ppn_of(input int n);
        case (n)
            0:       return 3;
            1:       return 17;
            2:       return 1;
            default: return 2;
        endcase
    endfunction

    function automatic logic [65:0] mask_of(input int n);
        return (n == 0) ? 66'h3FF : {66{1'b1}};
    endfunction

    function automatic logic [65:0] rnd66();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[65:0];
    endfunction

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_inv(input int n, input logic [65:0] acc);
        logic [65:0] m;
        m = mask_of(n);
        chk("invariant", (sum_w[n] + carry_w[n]) & m, acc & m);
    endtask

    // One full operation; acc is the reference running sum of accepted PPs.
    task automatic run_op(input int n, input logic [16:0][65:0] pps, input logic [8:0][3:0] gaps,
                          input bit poke, output logic [65:0] res, output int lat);
        int          cyc, ppn, b, gtot;
        logic [65:0] msk, acc, nxt;
        ppn  = ppn_of(n);
        b    = (ppn + 1) / 2;
        msk  = mask_of(n);
        acc  = '0;
        gtot = 0;
        start[n] = 1'b1;
        @(negedge clk);
        start[n] = 1'b0;
        cyc = 1;
        for (int i = 0; i < b; i++) begin
            for (int g = 0; g < int'(gaps[i]); g++) begin
                pp_valid[n] = 1'b0;
                if (poke && g == 0) start[n] = 1'b1;
                chk("ready_gap", ready_w[n], 1'b1);
                chk_inv(n, acc);
                @(negedge clk);
                start[n] = 1'b0;
                cyc++;
                gtot++;
            end
            chk("ready_beat", ready_w[n], 1'b1);
            chk("busy_beat", busy_w[n], 1'b1);
            chk_inv(n, acc);
            pp_valid[n] = 1'b1;
            pp0[n] = pps[2*i] & msk;
            nxt = acc + pp0[n];
            if (2*i + 1 < ppn) begin
                pp1[n] = pps[2*i+1] & msk;
                nxt = nxt + pp1[n];
            end else begin
                pp1[n] = (rnd66() & msk) | 66'd1;
            end
            @(negedge clk);
            cyc++;
            acc = nxt;
        end
        pp_valid[n] = 1'b0;
        for (int t = 0; t < 16 && done_w[n] !== 1'b1; t++) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", done_w[n], 1'b1);
        chk("latency", cyc, b + 1 + gtot);
        chk_inv(n, acc);
        res = (sum_w[n] + carry_w[n]) & msk;
        lat = cyc;
        if (poke) start[n] = 1'b1;
        @(negedge clk);
        start[n] = 1'b0;
        chk("done_width", done_w[n], 1'b0);
        chk("busy_after", busy_w[n], 1'b0);
    endtask

    initial begin
        logic [65:0]       res, exp;
        logic [16:0][65:0] pps;
        logic [8:0][3:0]   gaps;
        int                lat, n;
        bit                saw_done;

        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [65:0]       res, exp;
        logic [16:0][65:0] pps;
        logic [8:0][3:0]   gaps;
        int                lat, n;
        bit                saw_done;

        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            start[i] = 1'b0; pp_valid[i] = 1'b0; pp0[i] = '0; pp1[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("rst_ready", ready_w[i], 1'b0);
            chk("rst_busy", busy_w[i], 1'b0);
            chk("rst_done", done_w[i], 1'b0);
            chk("rst_sum", sum_w[i], '0);
            chk("rst_carry", carry_w[i], '0);
        end
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            tbl[i].pp = '0;
            tbl[i].gaps = '0;
        end
        tbl[0].n = 0; tbl[0].pp[0] = 66'd5; tbl[0].pp[1] = 66'd7; tbl[0].pp[2] = 66'd9;
        tbl[0].exp_sum = 66'd21; tbl[0].exp_lat = 3;
        tbl[1].n = 1; tbl[1].pp = {17{66'h3FFFFFFFFFFFFFFFF}};
        tbl[1].exp_sum = 66'h3FFFFFFFFFFFFFFEF; tbl[1].exp_lat = 10;
        tbl[2].n = 0; tbl[2].pp[0] = 66'd5; tbl[2].pp[1] = 66'd7; tbl[2].pp[2] = 66'd9;
        tbl[2].gaps[1] = 4'd3;
        tbl[2].exp_sum = 66'd21; tbl[2].exp_lat = 6;

        for (int i = 0; i < 3; i++) begin
            run_op(tbl[i].n, tbl[i].pp, tbl[i].gaps, 1'b0, res, lat);
            chk("tbl_sum", res, tbl[i].exp_sum);
            chk("tbl_lat", lat, tbl[i].exp_lat);
        end

        // Beats offered while idle must be refused and leave the last result alone.
        for (int i = 0; i < 3; i++) begin
            pp_valid[0] = 1'b1; pp0[0] = 66'd3; pp1[0] = 66'd4;
            @(negedge clk);
            chk("idle_ready", ready_w[0], 1'b0);
            chk("idle_busy", busy_w[0], 1'b0);
            chk_inv(0, 66'd21);
        end
        pp_valid[0] = 1'b0;

        // start pulses during ACC and DONE must not restart anything.
        gaps = '0; gaps[0] = 4'd2; gaps[1] = 4'd1;
        run_op(0, tbl[0].pp, gaps, 1'b1, res, lat);
        chk("poke_sum", res, 66'd21);
        chk("poke_lat", lat, 6);
        @(negedge clk);
        chk("poke_idle", busy_w[0], 1'b0);

        // Reset after the first of nine beats.
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        pp_valid[1] = 1'b1; pp0[1] = rnd66(); pp1[1] = rnd66();
        @(negedge clk);
        pp_valid[1] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", busy_w[1], 1'b0);
        chk("mid_rst_ready", ready_w[1], 1'b0);
        chk("mid_rst_sum", sum_w[1], '0);
        chk("mid_rst_carry", carry_w[1], '0);
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done_w[1] === 1'b1) saw_done = 1'b1;
            @(negedge clk);
        end
        chk("mid_rst_no_done", saw_done, 1'b0);
        for (int j = 0; j < 17; j++) pps[j] = rnd66();
        gaps = '0;
        exp = '0;
        for (int j = 0; j < 17; j++) exp = exp + pps[j];
        run_op(1, pps, gaps, 1'b0, res, lat);
        chk("post_rst_sum", res, exp);

        for (int op = 0; op < 1000; op++) begin
            n = 1 + (op % 3);
            for (int j = 0; j < 17; j++) pps[j] = rnd66();
            for (int j = 0; j < 9; j++) gaps[j] = 4'($urandom_range(0, 3));
            exp = '0;
            for (int j = 0; j < ppn_of(n); j++) exp = exp + pps[j];
            exp = exp & mask_of(n);
            run_op(n, pps, gaps, 1'b0, res, lat);
            chk("rand_sum", res, exp);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
